// File: rtl/uart_bus_ctrl_pkg.sv
// rtl/uart_bus_ctrl_pkg.sv - register map, status/control bit positions and TX FSM encoding
package uart_bus_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int STAT_RX_VALID  = 0;
  localparam int STAT_TX_READY  = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_TX_IDLE   = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  // Last WAIT_BUSY cycle before giving up on a transmitter that never went busy
  localparam logic [1:0] TX_TIMEOUT_LAST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_bus_ctrl_fifo.sv
// rtl/uart_bus_ctrl_fifo.sv - first-word fall-through synchronous FIFO used for RX and TX
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot
  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array carries no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2^AW
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_ctrl.sv
// rtl/uart_bus_ctrl.sv - bus-side register block, FIFOs and transmitter handshake for the UART
module uart_bus_ctrl
  import uart_bus_ctrl_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data
);

  logic              rd_en, wr_en;
  logic              rx_pop, tx_push, tx_pop;
  logic [7:0]        rx_head, tx_head;
  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic [FIFO_AW:0]  rx_count;
  logic [FIFO_AW:0]  unused_tx_count;
  logic              unused_bits;
  logic              overrun;
  logic [1:0]        ctrl;
  logic              tx_idle;
  tx_state_t         state, state_next;
  logic [1:0]        wait_cnt;
  logic [DATA_W-1:0] status_word, read_word;

  assign rd_en   = cs & ~we;
  assign wr_en   = cs & we;
  assign rx_pop  = rd_en & (addr == ADDR_DATA);
  assign tx_push = wr_en & (addr == ADDR_DATA);
  assign tx_idle = tx_empty & (state == ST_IDLE) & ~tx_busy;
  assign unused_bits = ^{wdata[DATA_W-1:8], unused_tx_count};

  uart_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_ready), .din(rx_data), .pop(rx_pop),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .din(wdata[7:0]), .pop(tx_pop),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(unused_tx_count)
  );

  // Sticky overrun (a lost byte outranks a same-cycle clear) and the interrupt enables
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
      ctrl    <= 2'b00;
    end else begin
      if (rx_ready && rx_full && !rx_pop)
        overrun <= 1'b1;
      else if (wr_en && addr == ADDR_STATUS && wdata[STAT_OVERRUN])
        overrun <= 1'b0;
      if (wr_en && addr == ADDR_CTRL)
        ctrl <= {wdata[CTRL_TX_IE], wdata[CTRL_RX_IE]};
    end
  end

  // Assemble the STATUS word
  always_comb begin
    status_word = '0;
    status_word[STAT_RX_VALID] = ~rx_empty;
    status_word[STAT_TX_READY] = ~tx_full;
    status_word[STAT_OVERRUN]  = overrun;
    status_word[STAT_TX_IDLE]  = tx_idle;
    status_word[STAT_COUNT_LSB +: FIFO_AW+1] = rx_count;
  end

  // Select the value returned for the current read address
  always_comb begin
    read_word = '0;
    case (addr)
      ADDR_DATA:   if (!rx_empty) read_word = {{(DATA_W-8){1'b0}}, rx_head};
      ADDR_STATUS: read_word = status_word;
      ADDR_CTRL:   read_word = {{(DATA_W-2){1'b0}}, ctrl};
      default:     read_word = '0;
    endcase
  end

  // Registered read data (held between reads) and registered interrupt level
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (rd_en) rdata <= read_word;
      irq <= (ctrl[CTRL_RX_IE] & ~rx_empty) | (ctrl[CTRL_TX_IE] & tx_empty);
    end
  end

  // TX FSM state register plus the WAIT_BUSY timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 2'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == ST_WAIT_BUSY) ? wait_cnt + 2'd1 : 2'd0;
    end
  end

  // TX FSM next state; IDLE never launches into a frame the transmitter is still sending
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (!tx_empty && !tx_busy) state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy) state_next = ST_WAIT_DONE;
                    else if (wait_cnt == TX_TIMEOUT_LAST) state_next = ST_IDLE;
      ST_WAIT_DONE: if (!tx_busy) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // TX FSM output: pop the head on the cycle the frame is launched
  always_comb begin
    tx_pop = 1'b0;
    if (state == ST_IDLE && !tx_empty && !tx_busy) tx_pop = 1'b1;
  end

  // Start pulse and byte are registered so reset forces both low immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= tx_pop;
      if (tx_pop) tx_data <= tx_head;
    end
  end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// tb/tb_uart_bus_ctrl.sv - scoreboard bench for uart_bus_ctrl
module tb_uart_bus_ctrl;
  import uart_bus_ctrl_pkg::*;

  localparam int FRAME_CYC = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        irq;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  assign tx_busy = model_busy | force_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_fall = 0;
  int busy_left = 0;
  bit busy_delay = 1'b0;

  logic [7:0]  exp_tx_q[$];
  logic [7:0]  obs_tx_q[$];
  int          obs_gap_q[$];
  logic        obs_busy_q[$];
  logic [31:0] rd_exp_q[$];

  always #5 clk = ~clk;

  uart_bus_ctrl #(.FIFO_AW(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .rx_ready(rx_ready), .rx_data(rx_data)
  );

  // Transmitter model: busy rises one cycle after a start and stays high FRAME_CYC cycles
  always @(negedge clk) begin
    logic busy_seen;
    busy_seen = model_busy | force_busy;
    cyc++;
    if (busy_delay) begin
      model_busy = 1'b1;
      busy_left  = FRAME_CYC;
      busy_delay = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        model_busy = 1'b0;
        last_fall  = cyc;
      end
    end
    if (tx_start === 1'b1) begin
      obs_tx_q.push_back(tx_data);
      obs_gap_q.push_back(cyc - last_fall);
      obs_busy_q.push_back(busy_seen);
      busy_delay = 1'b1;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = rdata;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_ready = 1'b1; rx_data = b;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_tx_done(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (obs_tx_q.size() >= n && busy_left == 0 && !busy_delay) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic [7:0]  e, o;
    int          g;
    logic        b;
    bit          ok;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    bus_read(ADDR_STATUS, r);
    checks++; if (r !== 32'h0000000A) begin errors++; $display("FAIL reset_status: got %h want %h", r, 32'h0000000A); end

    exp_tx_q.push_back(8'h33);
    bus_write(ADDR_DATA, 32'h33);
    repeat (6) @(negedge clk);
    bus_write(ADDR_DATA, 32'h99);
    rx_pulse(8'h22);
    bus_write(ADDR_CTRL, 32'h3);
    bus_read(ADDR_CTRL, r);
    checks++; if (r !== 32'h3) begin errors++; $display("FAIL ctrl_readback: got %h want %h", r, 32'h3); end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h want %h", rdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b want 0", irq); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL midrst_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx_data: got %h want 00", tx_data); end

    exp_tx_q.push_back(8'h44);
    bus_write(ADDR_DATA, 32'h44);
    bus_read(ADDR_STATUS, r);
    checks++; if (r !== 32'h00000002) begin errors++; $display("FAIL midrst_status_busy: got %h want %h", r, 32'h2); end
    wait_tx_done(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout: got %0d starts want 2", obs_tx_q.size()); end
    while (exp_tx_q.size() > 0) begin
      e = exp_tx_q.pop_front();
      checks++;
      if (obs_tx_q.size() == 0) begin errors++; $display("FAIL midrst_tx_missing: got none want %h", e); end
      else begin
        o = obs_tx_q.pop_front(); g = obs_gap_q.pop_front(); b = obs_busy_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL midrst_tx_data: got %h want %h", o, e); end
        checks++; if (b !== 1'b0) begin errors++; $display("FAIL midrst_start_busy: got busy=%b want 0", b); end
      end
    end
    checks++; if (obs_tx_q.size() != 0) begin errors++; $display("FAIL midrst_tx_extra: got %0d extra want 0", obs_tx_q.size()); end
    obs_tx_q.delete(); obs_gap_q.delete(); obs_busy_q.delete();
  endtask

  task automatic test_tx_handshake();
    logic [31:0] r;
    logic [7:0]  e, o;
    int          g;
    logic        b;
    bit          ok;
    exp_tx_q.push_back(8'h41);
    bus_write(ADDR_DATA, 32'h41);
    exp_tx_q.push_back(8'h42);
    bus_write(ADDR_DATA, 32'h42);
    wait_tx_done(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hs_timeout: got %0d starts want 2", obs_tx_q.size()); end
    while (exp_tx_q.size() > 0) begin
      e = exp_tx_q.pop_front();
      checks++;
      if (obs_tx_q.size() == 0) begin errors++; $display("FAIL hs_tx_missing: got none want %h", e); end
      else begin
        o = obs_tx_q.pop_front(); g = obs_gap_q.pop_front(); b = obs_busy_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL hs_tx_data: got %h want %h", o, e); end
        checks++; if (b !== 1'b0) begin errors++; $display("FAIL hs_start_busy: got busy=%b want 0", b); end
        checks++; if (g < 1) begin errors++; $display("FAIL hs_gap: got %0d want >=1", g); end
      end
    end
    checks++; if (obs_tx_q.size() != 0) begin errors++; $display("FAIL hs_tx_extra: got %0d extra want 0", obs_tx_q.size()); end
    obs_tx_q.delete(); obs_gap_q.delete(); obs_busy_q.delete();
    bus_read(ADDR_STATUS, r);
    checks++; if (r !== 32'h0000000A) begin errors++; $display("FAIL hs_tx_idle: got %h want %h", r, 32'hA); end
  endtask

  task automatic test_tx_full();
    logic [31:0] r;
    logic [7:0]  e, o;
    int          g;
    logic        b;
    bit          ok;
    force_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_tx_q.push_back(8'(i));
      bus_write(ADDR_DATA, 32'(i));
      if (i == 14) begin
        bus_read(ADDR_STATUS, r);
        checks++; if (r !== 32'h00000002) begin errors++; $display("FAIL full_15_status: got %h want %h", r, 32'h2); end
      end
      if (i == 15) begin
        bus_read(ADDR_STATUS, r);
        checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL full_16_status: got %h want %h", r, 32'h0); end
      end
    end
    force_busy = 1'b0;
    wait_tx_done(16, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout: got %0d starts want 16", obs_tx_q.size()); end
    while (exp_tx_q.size() > 0) begin
      e = exp_tx_q.pop_front();
      checks++;
      if (obs_tx_q.size() == 0) begin errors++; $display("FAIL full_tx_missing: got none want %h", e); end
      else begin
        o = obs_tx_q.pop_front(); g = obs_gap_q.pop_front(); b = obs_busy_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL full_tx_data: got %h want %h", o, e); end
        checks++; if (b !== 1'b0) begin errors++; $display("FAIL full_start_busy: got busy=%b want 0", b); end
        checks++; if (g < 1) begin errors++; $display("FAIL full_gap: got %0d want >=1", g); end
      end
    end
    checks++; if (obs_tx_q.size() != 0) begin errors++; $display("FAIL full_tx_extra: got %0d extra want 0", obs_tx_q.size()); end
    obs_tx_q.delete(); obs_gap_q.delete(); obs_busy_q.delete();
  endtask

  task automatic test_rx_overrun();
    logic [31:0] r, e;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) rd_exp_q.push_back(32'(i));
      rx_pulse(8'(i));
    end
    bus_read(ADDR_STATUS, r);
    checks++; if (r !== 32'h0000100F) begin errors++; $display("FAIL ovr_status_full: got %h want %h", r, 32'h100F); end
    while (rd_exp_q.size() > 0) begin
      e = rd_exp_q.pop_front();
      bus_read(ADDR_DATA, r);
      checks++; if (r !== e) begin errors++; $display("FAIL ovr_read: got %h want %h", r, e); end
    end
    bus_read(ADDR_STATUS, r);
    checks++; if (r !== 32'h0000000E) begin errors++; $display("FAIL ovr_sticky: got %h want %h", r, 32'hE); end
    bus_write(ADDR_STATUS, 32'h4);
    bus_read(ADDR_STATUS, r);
    checks++; if (r !== 32'h0000000A) begin errors++; $display("FAIL ovr_clear: got %h want %h", r, 32'hA); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] r, e;
    for (int i = 0; i < 16; i++) begin
      rd_exp_q.push_back(32'(8'h60 + i));
      rx_pulse(8'(8'h60 + i));
    end
    rd_exp_q.push_back(32'h55);
    cs = 1'b1; we = 1'b0; addr = ADDR_DATA; rx_ready = 1'b1; rx_data = 8'h55;
    @(negedge clk);
    cs = 1'b0; rx_ready = 1'b0;
    r = rdata;
    e = rd_exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL simul_read: got %h want %h", r, e); end
    bus_read(ADDR_STATUS, r);
    checks++; if (r !== 32'h0000100B) begin errors++; $display("FAIL simul_status: got %h want %h", r, 32'h100B); end
    while (rd_exp_q.size() > 0) begin
      e = rd_exp_q.pop_front();
      bus_read(ADDR_DATA, r);
      checks++; if (r !== e) begin errors++; $display("FAIL simul_drain: got %h want %h", r, e); end
    end
    bus_read(ADDR_DATA, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL empty_read: got %h want %h", r, 32'h0); end
  endtask

  task automatic test_irq();
    logic [31:0] r;
    bus_write(ADDR_CTRL, 32'h1);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
    rx_pulse(8'h77);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b want 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx: got %b want 1", irq); end
    bus_read(ADDR_DATA, r);
    checks++; if (r !== 32'h77) begin errors++; $display("FAIL irq_data: got %h want %h", r, 32'h77); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b want 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b want 0", irq); end
    bus_write(ADDR_CTRL, 32'h2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tx_lag: got %b want 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx: got %b want 1", irq); end
    bus_read(ADDR_CTRL, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL ctrl_tx_ie: got %h want %h", r, 32'h2); end
    bus_write(ADDR_CTRL, 32'hFFFFFFFF);
    bus_read(ADDR_CTRL, r);
    checks++; if (r !== 32'h3) begin errors++; $display("FAIL ctrl_mask: got %h want %h", r, 32'h3); end
    bus_write(2'd3, 32'hFFFFFFFF);
    bus_read(2'd3, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h want %h", r, 32'h0); end
    bus_write(ADDR_CTRL, 32'h0);
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_off: got %b want 0", irq); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_tx_handshake();
    test_tx_full();
    test_rx_overrun();
    test_simultaneous();
    test_irq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_bus_ctrl.md
Name: uart_bus_ctrl

Overview:
CPU-side responder for the serial port. It sits between the litecpu peripheral bus and the existing async transmitter/receiver pair. It provides a memory-mapped DATA, STATUS and CTRL register set, a TX FIFO that drives the transmitter's start/busy handshake, an RX FIFO fed by the receiver's data-ready pulse, and an interrupt output.

Parameters:
FIFO_AW, 4, log2 of each FIFO depth (depth = 2^FIFO_AW = 16 entries)
DATA_W, 32, bus data width; only bits [7:0] carry UART data

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-high reset
cs  in  1  bus select, one access per cycle while high
we  in  1  1 = write, 0 = read
addr  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
wdata  in  DATA_W  write data
rdata  out  DATA_W  registered read data
irq  out  1  level interrupt
tx_start  out  1  one-cycle start pulse to the transmitter
tx_data  out  8  byte to transmit, valid while tx_start = 1
tx_busy  in  1  transmitter busy
rx_ready  in  1  one-cycle pulse: a byte was received
rx_data  in  8  received byte, valid while rx_ready = 1

Behaviour:
- Reset values: rdata = 0, irq = 0, tx_start = 0, tx_data = 0. Both FIFOs empty, overrun = 0, CTRL = 0, TX FSM in IDLE.
- Reset mid-frame: the transmitter has no reset. The FSM leaves IDLE only when tx_busy = 0, so no start pulse is issued during a frame already in progress.
- Read latency is 1 cycle: rdata is registered from the access in cycle N and valid in cycle N+1. rdata holds its value when there is no read.
- DATA read: if the RX FIFO is non-empty, rdata = {24'b0, head} and the head is popped. If empty, rdata = 0 and no pop occurs.
- DATA write: push wdata[7:0] into the TX FIFO if not full. A write to a full TX FIFO is dropped silently.
- STATUS read layout:
  - bit0 rx_valid (RX FIFO not empty)
  - bit1 tx_ready (TX FIFO not full)
  - bit2 rx_overrun (sticky)
  - bit3 tx_idle (TX FIFO empty, FSM in IDLE, tx_busy = 0)
  - bits [8+FIFO_AW:8] RX count
  - remaining bits 0
- STATUS write: if wdata[2] = 1, clear rx_overrun. All other bits are ignored.
- CTRL read/write bits: bit0 rx_ie, bit1 tx_ie. Other bits read as 0.
- Reserved address (3): reads return 0; writes are ignored.
- irq = (rx_ie & rx_valid) | (tx_ie & TX FIFO empty). irq is registered, so it lags its conditions by 1 cycle.
- RX push: on rx_ready, push rx_data.
  - If the FIFO is full and there is no pop in the same cycle, drop the byte and set rx_overrun.
  - If the FIFO is full and a pop occurs in the same cycle, accept the byte; the count is unchanged.
- TX FSM:
  - IDLE: when TX FIFO non-empty and tx_busy = 0, drive tx_start = 1 for exactly one cycle with tx_data = head, pop the head, go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when tx_busy = 1. Timeout: after 4 cycles without busy, return to IDLE.
  - WAIT_DONE: go to IDLE when tx_busy = 0.
  - At most one start is issued per frame. Back-to-back bytes restart at the earliest 1 cycle after busy falls.
- FIFO arithmetic: pointers are FIFO_AW bits and wrap modulo the depth. The count is FIFO_AW+1 bits.
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
  - Push-while-empty-and-pop: the pop is ignored and the push succeeds.

Decomposition:
- Shared package: register address constants (ADDR_DATA, ADDR_STATUS, ADDR_CTRL), STATUS/CTRL bit indices, TX FSM state encoding.
- Natural sub-module: uart_sync_fifo (params WIDTH = 8, AW = FIFO_AW).
  - Ports: clk, rst, push, din, pop, dout (first-word fall-through head), full, empty, count.
  - Instantiated twice, once for RX and once for TX.

Test Plan:
- Reset: assert rst mid-operation → all outputs 0, STATUS reads 0x00000002 | tx_idle per tx_busy, no tx_start while tx_busy = 1.
- TX handshake: write 0x41, 0x42 to DATA; model busy high 1 cycle after start for 100 cycles → exactly two tx_start pulses, tx_data 0x41 then 0x42, second pulse ≥1 cycle after busy falls, tx_idle = 1 afterwards.
- TX full: 17 writes while tx_busy is held 1 → STATUS bit1 = 0 after the 16th write, 17th byte dropped; release busy → 16 starts carrying bytes 0..15.
- RX overrun: 17 rx_ready pulses with 0x00..0x10 and no reads → count 16, bit2 = 1; reads return 0x00..0x0F; STATUS write 0x4 → bit2 = 0.
- Simultaneous access: RX full, DATA read coincides with rx_ready 0x55 → no overrun, count stays 16, last read after draining = 0x55; empty DATA read returns 0.
- IRQ: CTRL = 1, one rx_ready → irq = 1 two cycles later, drops after the DATA read; CTRL = 2 with empty TX → irq = 1.
